// File: rtl/usb_reg_frontend_if.sv
// USB external-bus pins and single-clock register bus.
// slave = frontend side, master = host / register-block side.
interface usb_reg_frontend_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int BCNT_WIDTH = 16
);
  logic [7:0]            USB_Din;
  logic [7:0]            USB_Dout;
  logic                  USB_Doe;
  logic [7:0]            USB_Addr;
  logic                  USB_RDn;
  logic                  USB_WRn;
  logic                  USB_CEn;
  logic                  USB_ALEn;
  logic [ADDR_WIDTH-1:0] reg_address;
  logic [ADDR_WIDTH-1:0] reg_hypaddress;
  logic [BCNT_WIDTH-1:0] reg_bytecnt;
  logic [7:0]            reg_datao;
  logic [7:0]            reg_datai;
  logic [BCNT_WIDTH-1:0] reg_hyplen;
  logic [BCNT_WIDTH-1:0] reg_size;
  logic                  reg_read;
  logic                  reg_write;
  logic                  reg_addrvalid;
  logic                  proto_err;

  modport slave (
    input  USB_Din, USB_Addr,
    input  USB_RDn, USB_WRn,
    input  USB_CEn, USB_ALEn,
    input  reg_datai, reg_hyplen,
    output USB_Dout, USB_Doe,
    output reg_address, reg_hypaddress,
    output reg_bytecnt, reg_datao,
    output reg_size, reg_read,
    output reg_write, reg_addrvalid,
    output proto_err
  );

  modport master (
    output USB_Din, USB_Addr,
    output USB_RDn, USB_WRn,
    output USB_CEn, USB_ALEn,
    output reg_datai, reg_hyplen,
    input  USB_Dout, USB_Doe,
    input  reg_address, reg_hypaddress,
    input  reg_bytecnt, reg_datao,
    input  reg_size, reg_read,
    input  reg_write, reg_addrvalid,
    input  proto_err
  );
endinterface

// File: rtl/usb_reg_frontend.sv
// USB async strobe bus to single-clock register bus bridge.
// Strobes are synchronised, edge-detected and sequenced by one FSM.
module usb_reg_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 6,
  parameter int BCNT_WIDTH  = 16
) (
  input logic               clk,
  input logic               reset_i,
  usb_reg_frontend_if.slave bus
);
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int RD = 0;
  localparam int WR = 1;
  localparam int CE = 2;
  localparam int AL = 3;
  localparam logic [BCNT_WIDTH-1:0] ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_READY, S_RD, S_WR
  } state_e;

  logic [SS:0][3:0]      sync_q;
  logic [3:0]            cur;
  logic [3:0]            prv;
  logic                  ce_act;
  logic                  both_low;
  logic                  ale_fall, ale_rise;
  logic                  rd_fall, rd_rise;
  logic                  wr_fall, wr_rise;
  logic                  unused_addr;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BCNT_WIDTH-1:0] bcnt_q;
  logic [BCNT_WIDTH-1:0] size_q;
  logic [7:0]            datao_q;
  logic [7:0]            dout_q;
  logic                  rd_q;
  logic                  wr_q;
  logic                  addrv_q;
  logic                  doe_q;
  logic                  perr_q;
  logic                  size_pend_q;
  logic                  settle_q;
  logic                  inc_q;

  assign unused_addr = ^bus.USB_Addr;

  // Strobe synchronisers, idle-high after reset
  always_ff @(posedge clk) begin
    if (reset_i) sync_q <= '1;
    else sync_q <= {sync_q[SS-1:0],
                    bus.USB_ALEn, bus.USB_CEn,
                    bus.USB_WRn, bus.USB_RDn};
  end

  // Edge detection on the two oldest stages
  always_comb begin
    cur      = sync_q[SS-1];
    prv      = sync_q[SS];
    ce_act   = ~cur[CE] & ~prv[CE];
    both_low = ce_act & ~cur[RD] & ~cur[WR];
    ale_fall = prv[AL] & ~cur[AL];
    ale_rise = ~prv[AL] & cur[AL];
    rd_fall  = prv[RD] & ~cur[RD];
    rd_rise  = ~prv[RD] & cur[RD];
    wr_fall  = prv[WR] & ~cur[WR];
    wr_rise  = ~prv[WR] & cur[WR];
  end

  // Bus-cycle FSM with registered register-bus and pin outputs
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      bcnt_q      <= '0;
      size_q      <= '0;
      datao_q     <= '0;
      dout_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addrv_q     <= 1'b0;
      doe_q       <= 1'b0;
      perr_q      <= 1'b0;
      size_pend_q <= 1'b0;
      settle_q    <= 1'b0;
      inc_q       <= 1'b0;
    end else begin
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      size_pend_q <= 1'b0;
      settle_q    <= 1'b0;
      inc_q       <= 1'b0;
      if (size_pend_q) size_q <= bus.reg_hyplen;
      if (inc_q) bcnt_q <= bcnt_q + ONE;
      if (!ce_act) begin
        doe_q <= 1'b0;
      end else if (ale_fall) begin
        addr_q  <= bus.USB_Addr[ADDR_WIDTH-1:0];
        bcnt_q  <= '0;
        addrv_q <= 1'b0;
        doe_q   <= 1'b0;
        state_q <= S_ADDR;
      end else if (both_low) begin
        perr_q  <= 1'b1;
        doe_q   <= 1'b0;
        state_q <= S_READY;
      end else begin
        unique case (state_q)
          S_ADDR: begin
            if (ale_rise) begin
              addrv_q     <= 1'b1;
              size_pend_q <= 1'b1;
              state_q     <= S_READY;
            end
          end
          S_READY: begin
            if (rd_fall) begin
              rd_q    <= 1'b1;
              state_q <= S_RD;
            end else if (wr_fall) begin
              state_q <= S_WR;
            end
          end
          S_RD: begin
            if (rd_rise) begin
              doe_q   <= 1'b0;
              bcnt_q  <= bcnt_q + ONE;
              state_q <= S_READY;
            end else begin
              settle_q <= rd_q;
              if (settle_q) begin
                dout_q <= bus.reg_datai;
                doe_q  <= 1'b1;
              end
            end
          end
          S_WR: begin
            if (wr_rise) begin
              datao_q <= bus.USB_Din;
              wr_q    <= 1'b1;
              inc_q   <= 1'b1;
              state_q <= S_READY;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.USB_Dout       = dout_q;
  assign bus.USB_Doe        = doe_q;
  assign bus.reg_address    = addr_q;
  assign bus.reg_hypaddress = addr_q;
  assign bus.reg_bytecnt    = bcnt_q;
  assign bus.reg_datao      = datao_q;
  assign bus.reg_size       = size_q;
  assign bus.reg_read       = rd_q;
  assign bus.reg_write      = wr_q;
  assign bus.reg_addrvalid  = addrv_q;
  assign bus.proto_err      = perr_q;
endmodule

// File: tb/tb_usb_reg_frontend.sv
// Bench for usb_reg_frontend: host-side pin driver,
// register-bus monitor and a transaction-level model.
module tb_usb_reg_frontend;
  localparam int SS   = 2;
  localparam int AW   = 6;
  localparam int BW   = 8;
  localparam int HOLD = 5;
  localparam int OW   = 2*AW + 2*BW + 8 + 5 + 8;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  usb_reg_frontend_if #(
    .ADDR_WIDTH(AW), .BCNT_WIDTH(BW)
  ) bus ();

  usb_reg_frontend #(
    .SYNC_STAGES(SS),
    .ADDR_WIDTH(AW),
    .BCNT_WIDTH(BW)
  ) dut (
    .clk(clk),
    .reset_i(reset_i),
    .bus(bus)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [7:0]    d;
  } wr_t;

  int checks = 0;
  int failures = 0;
  wr_t wq[$];
  int rd_cnt = 0;
  int doe_cyc = 0;
  int both_cnt = 0;
  logic [7:0] last_dout = '0;

  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_bcnt;
  bit            m_valid;

  always @(negedge clk) begin
    if (!reset_i) begin
      if (bus.reg_write)
        wq.push_back('{bus.reg_address,
                       bus.reg_bytecnt,
                       bus.reg_datao});
      if (bus.reg_read) rd_cnt++;
      if (bus.reg_read && bus.reg_write) both_cnt++;
      if (bus.USB_Doe) begin
        doe_cyc++;
        last_dout = bus.USB_Dout;
      end
    end
  end

  function automatic logic [OW-1:0] outs();
    return {bus.reg_address, bus.reg_hypaddress,
            bus.reg_bytecnt, bus.reg_datao,
            bus.reg_size, bus.reg_read,
            bus.reg_write, bus.reg_addrvalid,
            bus.proto_err, bus.USB_Doe,
            bus.USB_Dout};
  endfunction

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_ale(input logic [7:0] a,
                          input logic [BW-1:0] len);
    bus.reg_hyplen = len;
    bus.USB_Addr = a;
    bus.USB_ALEn = 1'b0;
    nclk(HOLD);
    bus.USB_ALEn = 1'b1;
    nclk(HOLD);
  endtask

  task automatic host_wr(input logic [7:0] d);
    bus.USB_Din = d;
    bus.USB_WRn = 1'b0;
    nclk(HOLD);
    bus.USB_WRn = 1'b1;
    nclk(HOLD);
  endtask

  task automatic host_rd(input logic [7:0] d);
    bus.reg_datai = d;
    bus.USB_RDn = 1'b0;
    nclk(HOLD + 2);
    bus.USB_RDn = 1'b1;
    nclk(HOLD);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    nclk(3);
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=0", outs());
    end
    reset_i = 1'b0;
    nclk(4);
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL idle_outs got=%h exp=0", outs());
    end
    m_valid = 0;
  endtask

  task automatic test_write();
    logic [7:0] a;
    logic [BW-1:0] len;
    logic [7:0] d[4];
    int n;
    wr_t e;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        a = 8'h23; n = 2;
        d[0] = 8'hA5; d[1] = 8'h5A;
      end else begin
        a = 8'($urandom);
        n = $urandom_range(1, 4);
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      end
      len = BW'($urandom);
      host_ale(a, len);
      m_addr = a[AW-1:0]; m_bcnt = '0; m_valid = 1;
      wq.delete();
      checks++;
      if (bus.reg_address !== m_addr ||
          bus.reg_hypaddress !== m_addr) begin
        failures++;
        $display("FAIL wr_addr got=%h/%h exp=%h",
          bus.reg_address, bus.reg_hypaddress, m_addr);
      end
      checks++;
      if (bus.reg_size !== len || bus.reg_addrvalid !== 1'b1) begin
        failures++;
        $display("FAIL wr_size got=%h v=%b exp=%h v=1",
          bus.reg_size, bus.reg_addrvalid, len);
      end
      for (int i = 0; i < n; i++) host_wr(d[i]);
      checks++;
      if (wq.size() != n) begin
        failures++;
        $display("FAIL wr_count got=%0d exp=%0d", wq.size(), n);
      end
      for (int i = 0; i < n; i++) begin
        if (i < wq.size()) begin
          e.a = m_addr; e.b = BW'(i); e.d = d[i];
          checks++;
          if (wq[i] !== e) begin
            failures++;
            $display("FAIL wr_entry%0d got=%h exp=%h", i, wq[i], e);
          end
        end
      end
      m_bcnt = m_bcnt + BW'(n);
      checks++;
      if (bus.reg_bytecnt !== m_bcnt) begin
        failures++;
        $display("FAIL wr_bcnt got=%h exp=%h", bus.reg_bytecnt, m_bcnt);
      end
    end
  endtask

  task automatic test_write_latency();
    logic [7:0] din;
    logic [BW-1:0] bw, bn;
    logic [7:0] dw;
    int wk;
    host_ale(8'($urandom), BW'($urandom));
    din = 8'($urandom);
    bus.USB_Din = din;
    bus.USB_WRn = 1'b0;
    nclk(HOLD);
    bus.USB_WRn = 1'b1;
    wk = -1; bw = 'x; bn = 'x; dw = 'x;
    for (int k = 1; k <= 6; k++) begin
      nclk(1);
      if (wk > 0 && k == wk + 1) bn = bus.reg_bytecnt;
      if (bus.reg_write && wk < 0) begin
        wk = k; bw = bus.reg_bytecnt; dw = bus.reg_datao;
      end
    end
    nclk(HOLD);
    checks++;
    if (wk != SS + 1) begin
      failures++;
      $display("FAIL wr_latency got=%0d exp=%0d", wk, SS + 1);
    end
    checks++;
    if (bw !== '0 || dw !== din || bn !== BW'(1)) begin
      failures++;
      $display("FAIL wr_pulse bcnt=%h d=%h next=%h exp 0/%h/1",
        bw, dw, bn, din);
    end
    wq.delete();
    m_valid = 0;
  endtask

  task automatic test_read();
    logic [7:0] a, dat, dv;
    int rk, dk, ok, r0;
    for (int it = 0; it < 3; it++) begin
      a   = (it == 0) ? 8'h04 : 8'($urandom);
      dat = (it == 0) ? 8'h3C : 8'($urandom);
      host_ale(a, BW'($urandom));
      r0 = rd_cnt; rk = -1; dk = -1; ok = -1; dv = 'x;
      bus.reg_datai = dat;
      bus.USB_RDn = 1'b0;
      for (int k = 1; k <= HOLD + 2; k++) begin
        nclk(1);
        if (bus.reg_read && rk < 0) rk = k;
        if (bus.USB_Doe && dk < 0) begin
          dk = k; dv = bus.USB_Dout;
        end
      end
      bus.USB_RDn = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        nclk(1);
        if (!bus.USB_Doe && ok < 0) ok = k;
      end
      nclk(HOLD);
      checks++;
      if (rk != SS + 1 || rd_cnt - r0 != 1) begin
        failures++;
        $display("FAIL rd_strobe at=%0d n=%0d exp at=%0d n=1",
          rk, rd_cnt - r0, SS + 1);
      end
      checks++;
      if (dk != SS + 3 || dv !== dat) begin
        failures++;
        $display("FAIL rd_doe at=%0d dout=%h exp at=%0d dout=%h",
          dk, dv, SS + 3, dat);
      end
      checks++;
      if (ok != SS + 1) begin
        failures++;
        $display("FAIL rd_doe_off got=%0d exp=%0d", ok, SS + 1);
      end
      checks++;
      if (bus.reg_bytecnt !== BW'(1)) begin
        failures++;
        $display("FAIL rd_bcnt got=%h exp=1", bus.reg_bytecnt);
      end
    end
    m_valid = 0;
  endtask

  task automatic test_wrap();
    int bad;
    host_ale(8'($urandom), BW'($urandom));
    wq.delete();
    for (int i = 0; i < (1 << BW); i++) host_wr(8'(i));
    checks++;
    if (bus.reg_bytecnt !== '0) begin
      failures++;
      $display("FAIL wrap_bcnt got=%h exp=0", bus.reg_bytecnt);
    end
    host_wr(8'hC3);
    checks++;
    if (wq.size() != (1 << BW) + 1) begin
      failures++;
      $display("FAIL wrap_count got=%0d exp=%0d",
        wq.size(), (1 << BW) + 1);
    end
    bad = 0;
    for (int i = 0; i < wq.size(); i++)
      if (wq[i].b !== BW'(i) || wq[i].d !== 8'(i == (1 << BW) ? 8'hC3 : i))
        bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL wrap_entries bad=%0d exp=0", bad);
    end
    checks++;
    if (wq.size() == (1 << BW) + 1 &&
        (wq[(1 << BW) - 1].b !== {BW{1'b1}} || wq[1 << BW].b !== '0)) begin
      failures++;
      $display("FAIL wrap_edge got=%h,%h exp=%h,0",
        wq[(1 << BW) - 1].b, wq[1 << BW].b, {BW{1'b1}});
    end
    checks++;
    if (bus.proto_err !== 1'b0 || bus.reg_bytecnt !== BW'(1)) begin
      failures++;
      $display("FAIL wrap_after perr=%b bcnt=%h exp 0/1",
        bus.proto_err, bus.reg_bytecnt);
    end
    wq.delete();
    m_valid = 0;
  endtask

  task automatic test_proto();
    int r0, e0;
    logic [7:0] d;
    host_ale(8'($urandom), BW'($urandom));
    wq.delete();
    r0 = rd_cnt; e0 = doe_cyc;
    bus.USB_RDn = 1'b0;
    bus.USB_WRn = 1'b0;
    nclk(HOLD + 2);
    checks++;
    if (bus.proto_err !== 1'b1) begin
      failures++;
      $display("FAIL proto_set got=%b exp=1", bus.proto_err);
    end
    bus.USB_RDn = 1'b1;
    bus.USB_WRn = 1'b1;
    nclk(HOLD);
    checks++;
    if (wq.size() != 0 || rd_cnt != r0 || doe_cyc != e0) begin
      failures++;
      $display("FAIL proto_quiet wr=%0d rd=%0d doe=%0d exp 0/0/0",
        wq.size(), rd_cnt - r0, doe_cyc - e0);
    end
    d = 8'($urandom);
    host_wr(d);
    checks++;
    if (wq.size() != 1 || (wq.size() == 1 &&
        (wq[0].b !== '0 || wq[0].d !== d))) begin
      failures++;
      $display("FAIL proto_resume n=%0d exp=1 bcnt0 d=%h", wq.size(), d);
    end
    checks++;
    if (bus.proto_err !== 1'b1) begin
      failures++;
      $display("FAIL proto_sticky got=%b exp=1", bus.proto_err);
    end
    reset_i = 1'b1;
    nclk(2);
    reset_i = 1'b0;
    nclk(2);
    checks++;
    if (bus.proto_err !== 1'b0) begin
      failures++;
      $display("FAIL proto_clear got=%b exp=0", bus.proto_err);
    end
    wq.delete();
    m_valid = 0;
  endtask

  task automatic test_ce_high();
    logic [7:0] a, d;
    logic [BW-1:0] len;
    int r0, e0;
    a = 8'($urandom); len = BW'($urandom);
    host_ale(a, len);
    host_wr(8'($urandom));
    wq.delete();
    r0 = rd_cnt; e0 = doe_cyc;
    bus.USB_CEn = 1'b1;
    nclk(HOLD);
    host_ale(~a, ~len);
    host_wr(8'($urandom));
    host_rd(8'($urandom));
    bus.USB_CEn = 1'b0;
    nclk(HOLD);
    checks++;
    if (bus.reg_address !== a[AW-1:0] || bus.reg_size !== len ||
        bus.reg_addrvalid !== 1'b1) begin
      failures++;
      $display("FAIL ce_addr got=%h/%h/%b exp=%h/%h/1",
        bus.reg_address, bus.reg_size, bus.reg_addrvalid,
        a[AW-1:0], len);
    end
    checks++;
    if (wq.size() != 0 || rd_cnt != r0 || doe_cyc != e0 ||
        bus.reg_bytecnt !== BW'(1)) begin
      failures++;
      $display("FAIL ce_quiet wr=%0d rd=%0d doe=%0d bcnt=%h exp 0/0/0/1",
        wq.size(), rd_cnt - r0, doe_cyc - e0, bus.reg_bytecnt);
    end
    d = 8'($urandom);
    host_wr(d);
    checks++;
    if (wq.size() != 1 || (wq.size() == 1 &&
        (wq[0].b !== BW'(1) || wq[0].a !== a[AW-1:0]))) begin
      failures++;
      $display("FAIL ce_resume n=%0d exp=1 at bcnt 1", wq.size());
    end
    wq.delete();
    m_valid = 0;
  endtask

  task automatic test_reset_mid();
    int w, r0;
    host_ale(8'($urandom), BW'($urandom));
    bus.reg_datai = 8'($urandom) | 8'h01;
    bus.USB_RDn = 1'b0;
    w = 0;
    while (!bus.USB_Doe && w < 20) begin
      nclk(1);
      w++;
    end
    checks++;
    if (bus.USB_Doe !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_doe got=%b exp=1 (timeout)", bus.USB_Doe);
    end
    reset_i = 1'b1;
    nclk(1);
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL rst_mid_outs got=%h exp=0", outs());
    end
    reset_i = 1'b0;
    nclk(HOLD);
    wq.delete();
    r0 = rd_cnt;
    bus.USB_RDn = 1'b1;
    nclk(HOLD);
    host_wr(8'($urandom));
    host_rd(8'($urandom));
    checks++;
    if (wq.size() != 0 || rd_cnt != r0 ||
        bus.reg_addrvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_idle wr=%0d rd=%0d v=%b exp 0/0/0",
        wq.size(), rd_cnt - r0, bus.reg_addrvalid);
    end
    m_valid = 0;
  endtask

  task automatic test_random();
    int op, r0;
    logic [7:0] a, d;
    logic [BW-1:0] len;
    wr_t e;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 2);
      wq.delete();
      if (op == 0) begin
        a = 8'($urandom); len = BW'($urandom);
        host_ale(a, len);
        m_addr = a[AW-1:0]; m_bcnt = '0; m_valid = 1;
        checks++;
        if (bus.reg_address !== m_addr || bus.reg_size !== len) begin
          failures++;
          $display("FAIL rnd_ale got=%h/%h exp=%h/%h",
            bus.reg_address, bus.reg_size, m_addr, len);
        end
      end else if (op == 1) begin
        d = 8'($urandom);
        host_wr(d);
        e.a = m_addr; e.b = m_bcnt; e.d = d;
        checks++;
        if (wq.size() != (m_valid ? 1 : 0) ||
            (m_valid && wq.size() == 1 && wq[0] !== e)) begin
          failures++;
          $display("FAIL rnd_wr n=%0d got=%h exp=%h",
            wq.size(), (wq.size() > 0) ? wq[0] : '0, e);
        end
        if (m_valid) m_bcnt = m_bcnt + BW'(1);
      end else begin
        d = 8'($urandom);
        r0 = rd_cnt;
        host_rd(d);
        checks++;
        if (rd_cnt - r0 != (m_valid ? 1 : 0) ||
            (m_valid && last_dout !== d)) begin
          failures++;
          $display("FAIL rnd_rd n=%0d dout=%h exp=%h",
            rd_cnt - r0, last_dout, d);
        end
        if (m_valid) m_bcnt = m_bcnt + BW'(1);
      end
      checks++;
      if (m_valid && bus.reg_bytecnt !== m_bcnt) begin
        failures++;
        $display("FAIL rnd_bcnt got=%h exp=%h", bus.reg_bytecnt, m_bcnt);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.USB_Din   = '0;
    bus.USB_Addr  = '0;
    bus.USB_RDn   = 1'b1;
    bus.USB_WRn   = 1'b1;
    bus.USB_CEn   = 1'b0;
    bus.USB_ALEn  = 1'b1;
    bus.reg_datai = '0;
    bus.reg_hyplen = '0;
    m_addr = '0; m_bcnt = '0; m_valid = 0;
    test_reset();
    test_write();
    test_write_latency();
    test_read();
    test_wrap();
    test_proto();
    test_ce_high();
    test_reset_mid();
    test_random();
    checks++;
    if (both_cnt != 0) begin
      failures++;
      $display("FAIL rd_wr_overlap got=%0d exp=0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
